// File: rtl/rv_pkg.sv
// Shared pipeline types for the RV32I hazard controller: forwarding selects,
// result-source encodings and the memory-wait state encoding.
package rv_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_wait_state_e;

    // M-stage result is newer than W-stage, so it wins; x0 is hardwired zero.
    function automatic fwd_sel_e fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
        if (rs != 5'd0 && rs == rd_m && we_m)      return FWD_M;
        else if (rs != 5'd0 && rs == rd_w && we_w) return FWD_W;
        else                                       return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if
    import rv_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D, rs2D, rs1E, rs2E;
    logic [4:0]       rdE, rdM, rdW;
    logic             regwriteM, regwriteW;
    logic [1:0]       resultsrcE;
    logic             pcsrcE;
    logic             memreqM, memreadyM;
    logic             cnt_clr;
    fwd_sel_e         forwardAE, forwardBE;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
               resultsrcE, pcsrcE, memreqM, memreadyM, cnt_clr,
        input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
               resultsrcE, pcsrcE, memreqM, memreadyM, cnt_clr,
        output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    count <= '0;
        else if (clr)                  count <= '0;
        else if (inc && count != '1)   count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use and memory-wait stalls,
// control-transfer flushes, memory timeout and stall/flush performance counters.
module hazard_ctrl
    import rv_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam logic [0:0]       ST_IDLE   = 1'(IDLE);
    localparam logic [0:0]       ST_WAIT   = 1'(WAIT);
    localparam logic [TMO_W-1:0] WCNT_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [0:0]       state;
    logic [TMO_W-1:0] wcnt;
    logic             lwstall, memstall, tmo;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        lwstall  = 1'b0;
        tmo      = 1'b0;
        memstall = 1'b0;
        if (hz.resultsrcE == RESULT_LOAD && hz.rdE != 5'd0 &&
            (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D) && !hz.pcsrcE)
            lwstall = 1'b1;
        if (state == ST_WAIT && !hz.memreadyM && wcnt >= WCNT_LAST)
            tmo = 1'b1;
        memstall = hz.memreqM && !hz.memreadyM && !tmo;
    end

    assign hz.forwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);
    assign hz.forwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);

    // Reset holds every stage flushed and nothing stalled; a memory wait freezes
    // the pipe, so branch and load-use actions are deferred to the release cycle.
    assign hz.stallF  = rst_n & (lwstall | memstall);
    assign hz.stallD  = rst_n & (lwstall | memstall);
    assign hz.stallE  = rst_n & memstall;
    assign hz.stallM  = rst_n & memstall;
    assign hz.flushD  = !rst_n | (hz.pcsrcE & !memstall);
    assign hz.flushE  = !rst_n | ((lwstall | hz.pcsrcE) & !memstall);
    assign hz.flushW  = !rst_n | memstall;
    assign hz.mem_err = tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hz.memreqM && !hz.memreadyM) begin
                        state <= ST_WAIT;
                        wcnt  <= TMO_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (hz.memreadyM || tmo) begin
                        state <= ST_IDLE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hz.stallF),
        .clr   (hz.cnt_clr),
        .count (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hz.flushD | hz.flushE),
        .clr   (hz.cnt_clr),
        .count (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (short timeout, narrow counters).
module tb_hazard_ctrl;
    import rv_pkg::*;

    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(
        .CNT_W       (CNT_W),
        .TMO_W       (8),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0;
        hz.rdE = '0; hz.rdM = '0; hz.rdW = '0;
        hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
        hz.resultsrcE = 2'b00; hz.pcsrcE = 1'b0;
        hz.memreqM = 1'b0; hz.memreadyM = 1'b0; hz.cnt_clr = 1'b0;
    endtask

    // stallF, stallD, stallE, stallM, flushW packed for compact memory-wait checks
    function automatic logic [4:0] mem_view();
        return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushW};
    endfunction

    task automatic load_use_inputs();
        hz.resultsrcE = RESULT_LOAD;
        hz.rdE        = 5'd7;
        hz.rs2D       = 5'd7;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        rst_n = 1'b0;

        #3;
        check("rst_stalls", {hz.stallF, hz.stallD, hz.stallE, hz.stallM}, 4'b0000);
        check("rst_flushes", {hz.flushD, hz.flushE, hz.flushW}, 3'b111);
        check("rst_cnts", {hz.stall_cnt, hz.flush_cnt}, 8'h00);
        check("rst_mem_err", hz.mem_err, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        #2;
        check("idle_outputs", {mem_view(), hz.flushD, hz.flushE}, 7'b0);

        // forwarding priority and x0 exclusion
        hz.rs1E = 5'd5; hz.rdM = 5'd5; hz.regwriteM = 1'b1; hz.rdW = 5'd5; hz.regwriteW = 1'b1;
        #2; check("fwdA_M", hz.forwardAE, 2'b10);
        hz.regwriteM = 1'b0;
        #2; check("fwdA_W", hz.forwardAE, 2'b01);
        hz.rs1E = 5'd0;
        #2; check("fwdA_x0", hz.forwardAE, 2'b00);
        hz.rs2E = 5'd9; hz.rdM = 5'd9; hz.regwriteM = 1'b1; hz.rdW = 5'd3;
        #2; check("fwdB_M", hz.forwardBE, 2'b10);
        hz.rdM = 5'd4; hz.rdW = 5'd9;
        #2; check("fwdB_W", hz.forwardBE, 2'b01);
        hz.regwriteW = 1'b0;
        #2; check("fwdB_none", hz.forwardBE, 2'b00);

        // load-use hazard, then bubble, then branch-killed load-use
        next_cycle(); clear_inputs(); load_use_inputs();
        #2; check("lu_stall", {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE}, 5'b11001);
        next_cycle(); hz.rdE = 5'd0;
        #2; check("lu_release", {hz.stallF, hz.flushE}, 2'b00);
        next_cycle(); load_use_inputs(); hz.pcsrcE = 1'b1;
        #2; check("lu_branch", {hz.stallF, hz.flushD, hz.flushE}, 3'b011);
        next_cycle(); clear_inputs();
        #2; check("lu_cnts", {hz.stall_cnt, hz.flush_cnt}, {4'd1, 4'd2});
        hz.cnt_clr = 1'b1;
        next_cycle(); hz.cnt_clr = 1'b0;
        #2; check("cnt_clr", {hz.stall_cnt, hz.flush_cnt}, 8'h00);

        // memory wait with a pending branch held off until release
        for (int i = 0; i < 3; i++) begin
            next_cycle(); hz.memreqM = 1'b1; hz.memreadyM = 1'b0; hz.pcsrcE = 1'b1;
            #2; check($sformatf("mw_stall%0d", i), {mem_view(), hz.flushD, hz.flushE}, 7'b1111100);
        end
        next_cycle(); hz.memreadyM = 1'b1;
        #2; check("mw_release", {mem_view(), hz.flushD, hz.flushE, hz.mem_err}, 8'b00000110);
        next_cycle(); clear_inputs();
        #2; check("mw_cnts", {hz.stall_cnt, hz.flush_cnt}, {4'd3, 4'd1});

        // timeout: 3 stall cycles, error on the 4th, then a fresh wait restarts
        for (int i = 0; i < 3; i++) begin
            next_cycle(); hz.memreqM = 1'b1;
            #2; check($sformatf("tmo_stall%0d", i), {mem_view(), hz.mem_err}, 6'b111110);
        end
        next_cycle();
        #2; check("tmo_err", {mem_view(), hz.mem_err}, 6'b000001);
        next_cycle();
        #2; check("tmo_restart", {mem_view(), hz.mem_err}, 6'b111110);
        next_cycle(); hz.memreadyM = 1'b1;
        #2; check("tmo_restart_done", {mem_view(), hz.mem_err}, 6'b000000);

        // ready arriving on the timeout cycle wins over the timeout
        for (int i = 0; i < 3; i++) begin
            next_cycle(); hz.memreqM = 1'b1; hz.memreadyM = 1'b0;
        end
        next_cycle(); hz.memreadyM = 1'b1;
        #2; check("rdy_vs_tmo", {mem_view(), hz.mem_err}, 6'b000000);

        // counter saturation and clear priority over increment
        next_cycle(); clear_inputs(); hz.cnt_clr = 1'b1; load_use_inputs();
        for (int i = 0; i < 20; i++) begin
            next_cycle(); hz.cnt_clr = 1'b0;
        end
        #2; check("sat_stall", hz.stall_cnt, 4'hF);
        check("sat_flush", hz.flush_cnt, 4'hF);
        hz.cnt_clr = 1'b1;
        next_cycle(); hz.cnt_clr = 1'b0;
        #2; check("clr_over_inc", hz.stall_cnt, 4'h0);

        // asynchronous reset in the middle of a wait
        next_cycle(); clear_inputs(); hz.memreqM = 1'b1;
        next_cycle();
        #2; check("pre_rst_wait", {mem_view(), hz.stall_cnt != 4'h0}, 6'b111111);
        rst_n = 1'b0;
        #1;
        check("arst_stalls", {hz.stallF, hz.stallD, hz.stallE, hz.stallM}, 4'b0000);
        check("arst_flushes", {hz.flushD, hz.flushE, hz.flushW}, 3'b111);
        check("arst_cnts", {hz.stall_cnt, hz.flush_cnt}, 8'h00);
        next_cycle(); hz.memreqM = 1'b0;
        next_cycle(); rst_n = 1'b1;
        next_cycle();
        #2; check("post_rst_idle", {mem_view(), hz.flushD, hz.flushE, hz.mem_err}, 8'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); hz.memreqM = 1'b1;
            #2; check($sformatf("post_rst_wait%0d", i), {mem_view(), hz.mem_err}, 6'b111110);
        end
        next_cycle();
        #2; check("post_rst_tmo", {mem_view(), hz.mem_err}, 6'b000001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
